// File: rtl/pc_pkg.sv
// Shared op encodings for the program-counter sequencer.
package pc_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_INC  = 3'd1,
    OP_JMP  = 3'd2,
    OP_BR   = 3'd3,
    OP_CALL = 3'd4,
    OP_RET  = 3'd5
  } op_e;

endpackage

// File: rtl/pc_ras.sv
// Return-address LIFO: pointer-based storage with combinational full/empty flags.
module pc_ras #(
  parameter int ADDR_W    = 8,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top_data,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(RAS_DEPTH + 1);
  localparam int IW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     ptr_m1;

  assign ptr_m1   = ptr - PW'(1);
  assign top_data = mem[ptr_m1[IW-1:0]];
  assign full     = (ptr == PW'(RAS_DEPTH));
  assign empty    = (ptr == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (push && !full) begin
      ptr <= ptr + PW'(1);
    end else if (pop && !empty) begin
      ptr <= ptr_m1;
    end
  end

  // Storage holds data only, so it is left out of reset; the pointer alone defines validity.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[ptr[IW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer; return-address stack present only with PC_SEQUENCER_RAS_EN.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int STEP       = 2,
  parameter int RAS_DEPTH  = 4,
  parameter int RESET_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_en,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] target,
  input  logic [ADDR_W-1:0] offset,
  output logic [ADDR_W-1:0] pc,
  output logic              ras_full,
  output logic              ras_empty,
  output logic              err
);

  if (RAS_DEPTH < 1) begin : g_bad_depth
    $error("RAS_DEPTH must be at least 1");
  end

  logic signed [ADDR_W-1:0] offset_s;
  logic        [ADDR_W-1:0] pc_inc;
  logic        [ADDR_W-1:0] pc_br;

  // Two's-complement add is bit-identical to unsigned add modulo 2^ADDR_W.
  assign offset_s = signed'(offset);
  assign pc_inc   = pc + ADDR_W'(STEP);
  assign pc_br    = pc + $unsigned(offset_s);

`ifdef PC_SEQUENCER_RAS_EN
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] ras_top;

  assign push = pc_en && (op == OP_CALL) && !ras_full;
  assign pop  = pc_en && (op == OP_RET) && !ras_empty;

  pc_ras #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .push_data(pc_inc),
    .top_data (ras_top),
    .full     (ras_full),
    .empty    (ras_empty)
  );
`else
  assign ras_full  = 1'b0;
  assign ras_empty = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc  <= ADDR_W'(RESET_ADDR);
      err <= 1'b0;
    end else if (!pc_en) begin
      err <= 1'b0;
    end else begin
      err <= 1'b0;
      case (op)
        OP_NOP: ;
        OP_INC: pc <= pc_inc;
        OP_JMP: pc <= target;
        OP_BR:  pc <= pc_br;
`ifdef PC_SEQUENCER_RAS_EN
        OP_CALL: begin
          if (ras_full) err <= 1'b1;
          else          pc  <= target;
        end
        OP_RET: begin
          if (ras_empty) err <= 1'b1;
          else           pc  <= ras_top;
        end
`else
        OP_CALL: pc  <= target;
        OP_RET:  err <= 1'b1;
`endif
        default: err <= 1'b1;
      endcase
    end
  end

endmodule
